// File: rtl/io_sound_board.sv
// ============================================================================
// Module   : io_sound_board
// Purpose  : Memory/I/O glue for the sound CPU bus. It provides the following:
//            - decode of the 64 KB sound address space
//            - 4 KB work RAM
//            - chip selects for three 16 KB ROMs
//            - main<->sound mailbox latches
//            - music-chip reset latch
//            - CPU reset/NMI conditioning
//            - an optional periodic IRQ timer
// Options  : SND_TIMER_IRQ_EN - when defined, a free-running counter raises
//            cpu_irq_b every TIMER_DIV phi0 cycles. A write to 1830-183F
//            acknowledges it. When the macro is undefined, cpu_irq_b is
//            tied high.
// Ports    : phi0, SNDRST             clock, sync active-high reset
//            SNDNMI_b                 async NMI request from main CPU
//            SBA, SDout, SNDBW_b, SDin  sound CPU bus (SDin registered)
//            cpu_rst_b/nmi_b/irq_b    conditioned CPU control lines
//            SROM_b, rom_addr, rom_data  external ROM interface
//            RAM_CS0_b, RAM_CS1_b     RAM bank selects
//            MUSRES_b                 music chip reset latch
//            main_wdata, main_we      main->sound mailbox write
//            main_rdata, main_rd, snd_full  sound->main mailbox
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module io_sound_board #(
  parameter logic [15:0] TIMER_DIV = 16'd4096
) (
  input  logic        phi0,
  input  logic        SNDRST,
  input  logic        SNDNMI_b,
  input  logic [15:0] SBA,
  input  logic [7:0]  SDout,
  input  logic        SNDBW_b,
  output logic [7:0]  SDin,
  output logic        cpu_rst_b,
  output logic        cpu_nmi_b,
  output logic        cpu_irq_b,
  output logic [2:0]  SROM_b,
  output logic [13:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        RAM_CS0_b,
  output logic        RAM_CS1_b,
  output logic        MUSRES_b,
  input  logic [7:0]  main_wdata,
  input  logic        main_we,
  output logic [7:0]  main_rdata,
  input  logic        main_rd,
  output logic        snd_full
);

  logic [7:0] ram [0:4095];
  logic [7:0] m2s_latch;
  logic       main_full;
  logic       nmi_meta;
  logic [7:0] rd_mux;
  logic       cpu_wr;
  logic       sel_ram0, sel_ram1, sel_s2m, sel_m2s, sel_stat, sel_mus;
  logic       sel_rom0, sel_rom1, sel_rom2;

  assign cpu_wr = ~SNDBW_b;

  // Address decode: purely combinational from SBA
  assign sel_ram0 = (SBA[15:11] == 5'b00000);
  assign sel_ram1 = (SBA[15:11] == 5'b00001);
  assign sel_s2m  = (SBA[15:4] == 12'h100);
  assign sel_m2s  = (SBA[15:4] == 12'h101);
  assign sel_stat = (SBA[15:4] == 12'h102);
  assign sel_mus  = (SBA[15:4] == 12'h103);
  assign sel_rom0 = (SBA[15:14] == 2'b01);
  assign sel_rom1 = (SBA[15:14] == 2'b10);
  assign sel_rom2 = (SBA[15:14] == 2'b11);

  assign SROM_b    = ~{sel_rom2, sel_rom1, sel_rom0};
  assign RAM_CS0_b = ~sel_ram0;
  assign RAM_CS1_b = ~sel_ram1;
  assign rom_addr  = SBA[13:0];

  // Read data selection; unmapped and write-only locations read FF
  always_comb begin
    rd_mux = 8'hFF;
    if (sel_ram0 | sel_ram1)
      rd_mux = ram[SBA[11:0]];
    else if (sel_m2s)
      rd_mux = m2s_latch;
    else if (sel_stat)
      rd_mux = {main_full, snd_full, 6'b000000};
    else if (sel_rom0 | sel_rom1 | sel_rom2)
      rd_mux = rom_data;
  end

  // Work RAM is never cleared by reset
  always_ff @(posedge phi0) begin
    if (cpu_wr && (sel_ram0 | sel_ram1))
      ram[SBA[11:0]] <= SDout;
  end

  always_ff @(posedge phi0) begin
    // CPU reset trails SNDRST by one cycle in both directions
    cpu_rst_b <= ~SNDRST;
    if (SNDRST) begin
      SDin       <= 8'hFF;
      nmi_meta   <= 1'b1;
      cpu_nmi_b  <= 1'b1;
      MUSRES_b   <= 1'b0;
      main_full  <= 1'b0;
      snd_full   <= 1'b0;
      main_rdata <= 8'h00;
      m2s_latch  <= 8'h00;
    end else begin
      nmi_meta  <= SNDNMI_b;
      cpu_nmi_b <= nmi_meta;

      // SDin holds through write cycles
      if (!cpu_wr)
        SDin <= rd_mux;

      // A new main write beats a simultaneous CPU read; the read still
      // sees the old latch value because rd_mux samples before the update.
      if (main_we) begin
        m2s_latch <= main_wdata;
        main_full <= 1'b1;
      end else if (!cpu_wr && sel_m2s) begin
        main_full <= 1'b0;
      end

      // A CPU post beats a simultaneous main acknowledge
      if (cpu_wr && sel_s2m) begin
        main_rdata <= SDout;
        snd_full   <= 1'b1;
      end else if (main_rd) begin
        snd_full <= 1'b0;
      end

      if (cpu_wr && sel_mus)
        MUSRES_b <= SDout[7];
    end
  end

`ifdef SND_TIMER_IRQ_EN
  logic [15:0] tmr_cnt;
  logic        tmr_tc;
  logic        sel_ack;

  assign sel_ack = (SBA[15:4] == 12'h183);
  assign tmr_tc  = (tmr_cnt == TIMER_DIV - 16'd1);

  always_ff @(posedge phi0) begin
    if (SNDRST) begin
      tmr_cnt   <= 16'd0;
      cpu_irq_b <= 1'b1;
    end else begin
      tmr_cnt <= tmr_tc ? 16'd0 : tmr_cnt + 16'd1;
      // Terminal count wins over a same-cycle acknowledge
      if (tmr_tc)
        cpu_irq_b <= 1'b0;
      else if (cpu_wr && sel_ack)
        cpu_irq_b <= 1'b1;
    end
  end
`else
  logic unused_timer_div;
  assign unused_timer_div = ^TIMER_DIV;
  assign cpu_irq_b        = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_io_sound_board.sv
// ============================================================================
// Module   : tb_io_sound_board
// Purpose  : Self-checking bench for io_sound_board. It uses a vector table
//            for the decode/read path and hand sequences for mailboxes,
//            latches, NMI, reset and the IRQ timer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_io_sound_board;

  logic        phi0;
  logic        SNDRST;
  logic        SNDNMI_b;
  logic [15:0] SBA;
  logic [7:0]  SDout;
  logic        SNDBW_b;
  logic [7:0]  SDin;
  logic        cpu_rst_b, cpu_nmi_b, cpu_irq_b;
  logic [2:0]  SROM_b;
  logic [13:0] rom_addr;
  logic [7:0]  rom_data;
  logic        RAM_CS0_b, RAM_CS1_b, MUSRES_b;
  logic [7:0]  main_wdata;
  logic        main_we;
  logic [7:0]  main_rdata;
  logic        main_rd;
  logic        snd_full;

  int checks = 0;
  int errors = 0;

  io_sound_board #(.TIMER_DIV(16'd16)) dut (
    .phi0(phi0), .SNDRST(SNDRST), .SNDNMI_b(SNDNMI_b), .SBA(SBA),
    .SDout(SDout), .SNDBW_b(SNDBW_b), .SDin(SDin), .cpu_rst_b(cpu_rst_b),
    .cpu_nmi_b(cpu_nmi_b), .cpu_irq_b(cpu_irq_b), .SROM_b(SROM_b),
    .rom_addr(rom_addr), .rom_data(rom_data), .RAM_CS0_b(RAM_CS0_b),
    .RAM_CS1_b(RAM_CS1_b), .MUSRES_b(MUSRES_b), .main_wdata(main_wdata),
    .main_we(main_we), .main_rdata(main_rdata), .main_rd(main_rd),
    .snd_full(snd_full)
  );

  // ROM model: contents are the low address byte XOR 3C
  assign rom_data = SBA[7:0] ^ 8'h3C;

  initial phi0 = 1'b0;
  always #5 phi0 = ~phi0;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [15:0] sba;
    logic [7:0]  dout;
    logic [2:0]  srom;
    logic        cs0;
    logic        cs1;
    logic [7:0]  sdin;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge phi0);
    #1;
  endtask

  task automatic bus(input logic [15:0] a, input logic wr, input logic [7:0] d);
    SBA     = a;
    SNDBW_b = ~wr;
    SDout   = d;
    cyc();
    SNDBW_b = 1'b1;
  endtask

  initial begin
    // Post-reset decode/read sequence; writes must leave SDin unchanged
    vecs[0]  = '{1'b0, 16'hFFFC, 8'h00, 3'b011, 1'b1, 1'b1, 8'hC0};
    vecs[1]  = '{1'b0, 16'h4000, 8'h00, 3'b110, 1'b1, 1'b1, 8'h3C};
    vecs[2]  = '{1'b0, 16'h8012, 8'h00, 3'b101, 1'b1, 1'b1, 8'h2E};
    vecs[3]  = '{1'b1, 16'h0123, 8'hA5, 3'b111, 1'b0, 1'b1, 8'h2E};
    vecs[4]  = '{1'b1, 16'h0923, 8'h3C, 3'b111, 1'b1, 1'b0, 8'h2E};
    vecs[5]  = '{1'b1, 16'h0FFF, 8'h11, 3'b111, 1'b1, 1'b0, 8'h2E};
    vecs[6]  = '{1'b1, 16'h0800, 8'h22, 3'b111, 1'b1, 1'b0, 8'h2E};
    vecs[7]  = '{1'b0, 16'h0123, 8'h00, 3'b111, 1'b0, 1'b1, 8'hA5};
    vecs[8]  = '{1'b0, 16'h0923, 8'h00, 3'b111, 1'b1, 1'b0, 8'h3C};
    vecs[9]  = '{1'b0, 16'h0FFF, 8'h00, 3'b111, 1'b1, 1'b0, 8'h11};
    vecs[10] = '{1'b0, 16'h0800, 8'h00, 3'b111, 1'b1, 1'b0, 8'h22};
    vecs[11] = '{1'b0, 16'h1000, 8'h00, 3'b111, 1'b1, 1'b1, 8'hFF};
    vecs[12] = '{1'b0, 16'h1010, 8'h00, 3'b111, 1'b1, 1'b1, 8'h00};
    vecs[13] = '{1'b0, 16'h1020, 8'h00, 3'b111, 1'b1, 1'b1, 8'h00};
    vecs[14] = '{1'b0, 16'h2000, 8'h00, 3'b111, 1'b1, 1'b1, 8'hFF};
    vecs[15] = '{1'b0, 16'h3FFF, 8'h00, 3'b111, 1'b1, 1'b1, 8'hFF};
    vecs[16] = '{1'b0, 16'h1030, 8'h00, 3'b111, 1'b1, 1'b1, 8'hFF};
    vecs[17] = '{1'b0, 16'hBFFF, 8'h00, 3'b101, 1'b1, 1'b1, 8'hC3};
    vecs[18] = '{1'b0, 16'hC000, 8'h00, 3'b011, 1'b1, 1'b1, 8'h3C};

    SNDRST = 1'b1; SNDNMI_b = 1'b1; SBA = 16'h2000; SDout = 8'h00;
    SNDBW_b = 1'b1; main_wdata = 8'h00; main_we = 1'b0; main_rd = 1'b0;

    // Reset
    cyc(); cyc();
    chk("rst_cpu_rst_b", {15'd0, cpu_rst_b}, 16'h0);
    chk("rst_musres_b",  {15'd0, MUSRES_b}, 16'h0);
    chk("rst_snd_full",  {15'd0, snd_full}, 16'h0);
    chk("rst_sdin",      {8'd0, SDin}, 16'h00FF);
    chk("rst_nmi",       {15'd0, cpu_nmi_b}, 16'h1);
    chk("rst_irq",       {15'd0, cpu_irq_b}, 16'h1);
    chk("rst_main_rdata", {8'd0, main_rdata}, 16'h0000);
    SNDRST = 1'b0;
    #1;
    chk("rel_cpu_rst_b_hold", {15'd0, cpu_rst_b}, 16'h0);
    cyc();
    chk("rel_cpu_rst_b", {15'd0, cpu_rst_b}, 16'h1);

    // Table-driven decode and read path
    for (int i = 0; i < 19; i++) begin
      SBA     = vecs[i].sba;
      SNDBW_b = ~vecs[i].wr;
      SDout   = vecs[i].dout;
      #1;
      chk($sformatf("v%0d_srom", i), {13'd0, SROM_b}, {13'd0, vecs[i].srom});
      chk($sformatf("v%0d_cs0", i), {15'd0, RAM_CS0_b}, {15'd0, vecs[i].cs0});
      chk($sformatf("v%0d_cs1", i), {15'd0, RAM_CS1_b}, {15'd0, vecs[i].cs1});
      chk($sformatf("v%0d_rom_addr", i), {2'd0, rom_addr}, {2'd0, vecs[i].sba[13:0]});
      @(posedge phi0);
      #1;
      chk($sformatf("v%0d_sdin", i), {8'd0, SDin}, {8'd0, vecs[i].sdin});
    end
    SNDBW_b = 1'b1;

    // Main-to-sound mailbox
    main_we = 1'b1; main_wdata = 8'h5A;
    bus(16'h2000, 1'b0, 8'h00);
    main_we = 1'b0;
    bus(16'h1020, 1'b0, 8'h00); chk("m2s_status_full", {8'd0, SDin}, 16'h0080);
    bus(16'h1010, 1'b0, 8'h00); chk("m2s_data", {8'd0, SDin}, 16'h005A);
    bus(16'h1020, 1'b0, 8'h00); chk("m2s_status_clr", {8'd0, SDin}, 16'h0000);
    // Same-cycle main write and CPU read: old data returned, full stays set
    main_we = 1'b1; main_wdata = 8'h99;
    bus(16'h1010, 1'b0, 8'h00);
    main_we = 1'b0;
    chk("m2s_coll_old", {8'd0, SDin}, 16'h005A);
    bus(16'h1020, 1'b0, 8'h00); chk("m2s_coll_full", {8'd0, SDin}, 16'h0080);
    bus(16'h1010, 1'b0, 8'h00); chk("m2s_coll_new", {8'd0, SDin}, 16'h0099);
    bus(16'h1020, 1'b0, 8'h00); chk("m2s_coll_clr", {8'd0, SDin}, 16'h0000);

    // Sound-to-main mailbox
    bus(16'h1000, 1'b1, 8'h77);
    chk("s2m_full", {15'd0, snd_full}, 16'h1);
    chk("s2m_rdata", {8'd0, main_rdata}, 16'h0077);
    bus(16'h1020, 1'b0, 8'h00); chk("s2m_status", {8'd0, SDin}, 16'h0040);
    main_rd = 1'b1; bus(16'h2000, 1'b0, 8'h00); main_rd = 1'b0;
    chk("s2m_ack", {15'd0, snd_full}, 16'h0);
    main_rd = 1'b1; bus(16'h1000, 1'b1, 8'h33); main_rd = 1'b0;
    chk("s2m_coll_full", {15'd0, snd_full}, 16'h1);
    chk("s2m_coll_rdata", {8'd0, main_rdata}, 16'h0033);
    main_rd = 1'b1; bus(16'h2000, 1'b0, 8'h00); main_rd = 1'b0;
    chk("s2m_coll_ack", {15'd0, snd_full}, 16'h0);

    // Music reset latch follows bit 7 only
    bus(16'h1030, 1'b1, 8'h80); chk("musres_set", {15'd0, MUSRES_b}, 16'h1);
    bus(16'h103F, 1'b1, 8'h7F); chk("musres_clr", {15'd0, MUSRES_b}, 16'h0);
    bus(16'h1030, 1'b1, 8'hFF); chk("musres_set2", {15'd0, MUSRES_b}, 16'h1);

    // NMI synchronizer: two-cycle delay
    SNDNMI_b = 1'b0;
    cyc(); chk("nmi_d1", {15'd0, cpu_nmi_b}, 16'h1);
    cyc(); chk("nmi_d2", {15'd0, cpu_nmi_b}, 16'h0);
    SNDNMI_b = 1'b1;
    cyc(); cyc(); chk("nmi_release", {15'd0, cpu_nmi_b}, 16'h1);

    // Reset mid-operation overrides same-cycle flag updates
    main_we = 1'b1; main_wdata = 8'h44; SNDRST = 1'b1;
    bus(16'h1000, 1'b1, 8'h55);
    main_we = 1'b0;
    chk("mid_rst_snd_full", {15'd0, snd_full}, 16'h0);
    chk("mid_rst_rdata", {8'd0, main_rdata}, 16'h0000);
    chk("mid_rst_musres", {15'd0, MUSRES_b}, 16'h0);
    chk("mid_rst_sdin", {8'd0, SDin}, 16'h00FF);
    chk("mid_rst_cpu_rst", {15'd0, cpu_rst_b}, 16'h0);
    SNDRST = 1'b0;
    cyc();
    bus(16'h1020, 1'b0, 8'h00); chk("mid_rst_status", {8'd0, SDin}, 16'h0000);
    bus(16'h1010, 1'b0, 8'h00); chk("mid_rst_latch", {8'd0, SDin}, 16'h0000);
    bus(16'h0123, 1'b0, 8'h00); chk("ram_kept", {8'd0, SDin}, 16'h00A5);

`ifdef SND_TIMER_IRQ_EN
    SNDRST = 1'b1; cyc(); SNDRST = 1'b0; SBA = 16'h2000;
    repeat (15) cyc();
    chk("irq_before_tc", {15'd0, cpu_irq_b}, 16'h1);
    cyc();
    chk("irq_at_tc", {15'd0, cpu_irq_b}, 16'h0);
    repeat (3) cyc();
    chk("irq_held", {15'd0, cpu_irq_b}, 16'h0);
    bus(16'h1830, 1'b1, 8'h00);
    chk("irq_ack", {15'd0, cpu_irq_b}, 16'h1);
`else
    repeat (40) cyc();
    chk("irq_idle", {15'd0, cpu_irq_b}, 16'h1);
    bus(16'h1830, 1'b1, 8'h00);
    chk("irq_ack_ignored", {15'd0, cpu_irq_b}, 16'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/io_sound_board.md
Name: io_sound_board

Overview:
Memory/I/O glue for the sound subsystem. It sits between the sound CPU bus, implemented as a separate 6502 core module, and the rest of the sound board.
- Decodes the 64 KB sound address space.
- Holds 4 KB work RAM and drives chip selects for three external 16 KB program ROMs.
- Provides main↔sound mailbox latches, the music-chip reset latch and NMI/reset conditioning for the CPU.

Parameters:
- TIMER_DIV, 16'd4096: phi0 cycles between periodic IRQs (used only when SND_TIMER_IRQ_EN is defined).

Ports:
- phi0  in  1  system clock; all state changes on rising edge.
- SNDRST  in  1  synchronous active-high reset.
- SNDNMI_b  in  1  active-low NMI request from main CPU.
- SBA  in  16  sound CPU address.
- SDout  in  8  CPU write data.
- SNDBW_b  in  1  CPU write strobe, active low; high = read.
- SDin  out  8  read data to CPU (registered).
- cpu_rst_b  out  1  CPU reset, active low.
- cpu_nmi_b  out  1  CPU NMI, active low.
- cpu_irq_b  out  1  CPU IRQ, active low.
- SROM_b  out  3  ROM chip selects, active low; bit0=rom0, bit1=rom1, bit2=rom2.
- rom_addr  out  14  ROM word address = SBA[13:0].
- rom_data  in  8  data from the selected ROM (combinational from ROM).
- RAM_CS0_b, RAM_CS1_b  out  1 each  RAM bank selects, active low.
- MUSRES_b  out  1  music chip reset, active low.
- main_wdata  in  8  main-to-sound data.
- main_we  in  1  main CPU writes mailbox (1-cycle pulse).
- main_rdata  out  8  sound-to-main data.
- main_rd  in  1  main CPU acknowledges sound-to-main (1-cycle pulse).
- snd_full  out  1  sound-to-main mailbox full.

Behaviour:
- All address decode outputs (SROM_b, RAM_CS*_b, rom_addr) are combinational from SBA.
- Memory map:
  - 0000-07FF: RAM bank0, RAM_CS0_b=0.
  - 0800-0FFF: RAM bank1, RAM_CS1_b=0.
  - 1000-100F: write loads sound-to-main latch and sets snd_full. Read returns FF.
  - 1010-101F: read returns main-to-sound latch and clears main_full. Write is ignored.
  - 1020-102F: read status {main_full, snd_full, 6'b0}.
  - 1030-103F: write MUSRES_b <= SDout[7].
  - 1830-183F: write is IRQ acknowledge.
  - 4000-7FFF: SROM_b=3'b110.
  - 8000-BFFF: SROM_b=3'b101.
  - C000-FFFF: SROM_b=3'b011.
- All other addresses read FF; writes to them are ignored.
- Writes to ROM space are ignored; ROM selects still assert.
- RAM: 4096x8, synchronous write when SNDBW_b=0 and a bank is selected.
- Read path: SDin registered. It shows the data for the address presented in the previous cycle (1-cycle latency) and holds its value during write cycles.
- Mailbox main-to-sound:
  - main_we loads the latch and sets main_full.
  - A CPU read of 1010 in the same cycle as main_we: set wins, and the old latch value is returned.
- Mailbox sound-to-main:
  - main_rd clears snd_full.
  - A CPU write to 1000 in the same cycle as main_rd: set wins.
- cpu_rst_b = registered ~SNDRST (1-cycle delay).
- cpu_nmi_b = SNDNMI_b delayed through a 2-flop synchronizer.
- Reset values while SNDRST=1:
  - SDin=FF.
  - cpu_rst_b=0, cpu_nmi_b=1, cpu_irq_b=1.
  - MUSRES_b=0.
  - main_full=0, snd_full=0.
  - main_rdata=00, main-to-sound latch=00.
  - RAM contents are not cleared.
- Reset mid-operation overrides every pending flag update in that cycle.

Optional Feature:
- SND_TIMER_IRQ_EN defined:
  - A free-running counter counts TIMER_DIV cycles; at terminal count cpu_irq_b goes to 0.
  - cpu_irq_b stays 0 until a write to 1830-183F returns it to 1.
  - Ack and terminal count in the same cycle: irq stays asserted.
  - The counter resets to 0 on SNDRST.
- Not defined: cpu_irq_b tied 1, no counter, writes to 1830 ignored.

Test Plan:
- Reset: SNDRST=1 for 2 cycles → cpu_rst_b=0, MUSRES_b=0, snd_full=0, SDin=FF. Release → cpu_rst_b=1 one cycle later.
- ROM decode:
  - SBA=FFFC, read → SROM_b=011, rom_addr=3FFC, SDin=rom_data next cycle.
  - SBA=4000 → SROM_b=110.
  - SBA=8000 → SROM_b=101.
- RAM: write A5 to 0123 and 3C to 0923; read back → SDin=A5 then 3C. RAM_CS0_b and RAM_CS1_b each assert only in their own range.
- Mailboxes:
  - main_we with 5A → status read at 1020 = 80; read 1010 → 5A, then status = 00.
  - CPU writes 77 to 1000 → snd_full=1, main_rdata=77; main_rd → snd_full=0.
- Latches and NMI:
  - Write 80 to 1030 → MUSRES_b=1; write 00 → MUSRES_b=0.
  - SNDNMI_b low → cpu_nmi_b low after 2 cycles.
  - Read 2000 → SDin=FF.
- With SND_TIMER_IRQ_EN and TIMER_DIV=16: cpu_irq_b falls after 16 cycles and stays low until a write to 1830.
